// File: rtl/demux1t2_32_buf.sv
// Buffered 1:2 demux: routes one valid/ready word stream to two
// sinks, each fronted by its own small FIFO so one stall can't block the other.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_data  source handshake and word
//   s                          route select (0 -> ch0, 1 -> ch1)
//   o0_valid/o0_ready/o0_data  channel 0 sink handshake and head word
//   o1_valid/o1_ready/o1_data  channel 1 sink handshake and head word
//   o0_count/o1_count          per-channel FIFO occupancy

module demux1t2_32_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;

  // An empty FIFO ignores the sink's ready, so it can never underflow.
  assign valid_o = (cnt_q != '0);
  assign pop     = valid_o & ready_i;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop)    rptr_d = rptr_q + AW'(1);
    unique case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

module demux1t2_32_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic [CW-1:0]    o0_count,
  output logic [CW-1:0]    o1_count
);

  logic full0, full1;
  logic push0, push1;

  // Ready looks only at the registered count: a full FIFO refuses
  // even when its sink drains on the same edge.
  assign in_ready = s ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & ~s;
  assign push1    = in_valid & in_ready &  s;

  demux1t2_32_buf_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ch0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push0),
    .data_i (in_data),
    .ready_i(o0_ready),
    .valid_o(o0_valid),
    .data_o (o0_data),
    .count_o(o0_count),
    .full_o (full0)
  );

  demux1t2_32_buf_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ch1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push1),
    .data_i (in_data),
    .ready_i(o1_ready),
    .valid_o(o1_valid),
    .data_o (o1_data),
    .count_o(o1_count),
    .full_o (full1)
  );

endmodule

// File: tb/tb_demux1t2_32_buf.sv
// Self-checking bench for demux1t2_32_buf: directed scenarios plus a
// random run, compared against per-channel queue models.

module tb_demux1t2_32_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        s;
  logic        o0_valid, o0_ready;
  logic [31:0] o0_data;
  logic        o1_valid, o1_ready;
  logic [31:0] o1_data;
  logic [1:0]  o0_count, o1_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] sink0[$];
  bit          last_acc;

  always #5 clk = ~clk;

  demux1t2_32_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .s       (s),
    .o0_valid(o0_valid),
    .o0_ready(o0_ready),
    .o0_data (o0_data),
    .o1_valid(o1_valid),
    .o1_ready(o1_ready),
    .o1_data (o1_data),
    .o0_count(o0_count),
    .o1_count(o1_count)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then take one clock edge and
  // advance the model by what the handshake rules allow.
  task automatic cyc();
    bit rdy, pop0, pop1, acc;
    #1;
    rdy = s ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("o0_count", 32'(o0_count), q0.size());
    chk("o1_count", 32'(o1_count), q1.size());
    chk("o0_valid", 32'(o0_valid), 32'(q0.size() != 0));
    chk("o1_valid", 32'(o1_valid), 32'(q1.size() != 0));
    chk("o0_le_depth", 32'(o0_count <= 2'(DEPTH)), 32'd1);
    if (q0.size() != 0) chk("o0_data", o0_data, q0[0]);
    if (q1.size() != 0) chk("o1_data", o1_data, q1[0]);
    pop0 = (q0.size() != 0) && o0_ready;
    pop1 = (q1.size() != 0) && o1_ready;
    acc  = in_valid && rdy;
    if (pop0) sink0.push_back(o0_data);
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(in_data);
      else   q0.push_back(in_data);
    end
    last_acc = acc;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    s        = 1'b0;
    o0_ready = 1'b0;
    o1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o0_data", o0_data, 32'h0);
    chk("rst_o1_data", o1_data, 32'h0);
    chk("rst_o0_valid", 32'(o0_valid), 32'd0);
    chk("rst_o1_count", 32'(o1_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing with both sinks ready.
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    s        = 1'b0;
    cyc();
    chk("route_ch0_data", o0_data, 32'hDEADBEEF);
    chk("route_ch0_valid", 32'(o0_valid), 32'd1);
    in_data = 32'h12345678;
    s       = 1'b1;
    cyc();
    chk("route_ch1_data", o1_data, 32'h12345678);
    chk("route_ch0_gone", 32'(o0_valid), 32'd0);
    in_valid = 1'b0;
    cyc();
    chk("route_ch1_gone", 32'(o1_valid), 32'd0);

    // Full channel 0 backpressures only channel 0.
    o0_ready = 1'b0;
    o1_ready = 1'b0;
    in_valid = 1'b1;
    s        = 1'b0;
    in_data  = 32'h1;
    cyc();
    in_data = 32'h2;
    cyc();
    chk("full_count", 32'(o0_count), 32'd2);
    in_data = 32'h3;
    cyc();
    chk("full_not_acc", 32'(last_acc), 32'd0);
    s = 1'b1;
    cyc();
    chk("other_acc", 32'(last_acc), 32'd1);
    chk("other_data", o1_data, 32'h3);
    chk("other_ch0_kept", 32'(o0_count), 32'd2);
    in_valid = 1'b0;
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    repeat (3) cyc();

    // Simultaneous push and pop on channel 1.
    o1_ready = 1'b0;
    in_valid = 1'b1;
    s        = 1'b1;
    in_data  = 32'h44;
    cyc();
    in_data  = 32'h55;
    o1_ready = 1'b1;
    cyc();
    chk("pp_count", 32'(o1_count), 32'd1);
    chk("pp_data", o1_data, 32'h55);
    in_valid = 1'b0;
    cyc();

    // Wrap and order with a random sink.
    sink0.delete();
    s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + i;
      for (int t = 0; t < 50; t++) begin
        o0_ready = 1'($urandom);
        cyc();
        if (last_acc) break;
      end
      chk("wrap_push_acc", 32'(last_acc), 32'd1);
    end
    in_valid = 1'b0;
    for (int t = 0; t < 50 && q0.size() != 0; t++) begin
      o0_ready = 1'($urandom);
      cyc();
    end
    chk("wrap_sink_len", sink0.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < sink0.size()) chk("wrap_order", sink0[i], 32'hA0 + i);
    end

    // Empty FIFO ignores ready.
    o0_ready = 1'b1;
    repeat (5) begin
      cyc();
      chk("empty_count", 32'(o0_count), 32'd0);
      chk("empty_valid", 32'(o0_valid), 32'd0);
    end

    // Random mixed traffic; source holds its word until accepted.
    in_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom);
        s        = 1'($urandom);
        in_data  = $urandom;
      end
      o0_ready = ($urandom_range(3) != 0);
      o1_ready = ($urandom_range(3) == 0);
      cyc();
    end
    in_valid = 1'b0;

    // Asynchronous reset with channel 0 holding two words.
    o0_ready = 1'b0;
    o1_ready = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b1;
    s        = 1'b0;
    in_data  = 32'hC0;
    cyc();
    in_data = 32'hC1;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(o0_count), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_o0_valid", 32'(o0_valid), 32'd0);
    chk("arst_o0_data", o0_data, 32'h0);
    chk("arst_o0_count", 32'(o0_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o0_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hE0;
    cyc();
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
